// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial add/subtract controller.
//
// Time-shares one full_add cell across a WIDTH-bit operand pair, LSB first,
// one bit per clock. Operands are latched on an accepted start, the running
// carry lives in a flop and the result is assembled in a shift register.
// The visible result (sum/cout/ovf) is committed only on entry to DONE, so
// a partially computed result is never visible.
//
// Ports:
//   clk    rising-edge clock
//   rst    synchronous, active-high reset
//   start  request, accepted in IDLE or DONE only
//   sub    0 = a_in + b_in + cin, 1 = a_in - b_in (cin ignored)
//   a_in   operand A, latched with start
//   b_in   operand B, latched with start
//   cin    carry-in for add, latched with start
//   busy   high while bits are being processed
//   done   one-cycle pulse, result valid
//   sum    result, held until the next operation's done
//   cout   carry out of MSB (for sub: 1 = no borrow)
//   ovf    two's-complement overflow

// One-bit full adder cell shared by the serial datapath.
module full_add (
    input  logic a,
    input  logic b,
    input  logic c1,
    output logic s,
    output logic c2
);

    assign s  = a ^ b ^ c1;
    assign c2 = (a & b) | (c1 & (a ^ b));

endmodule

module serial_add_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_sh_q, a_sh_d;
    logic [WIDTH-1:0]  b_sh_q, b_sh_d;
    logic              sub_q, sub_d;
    logic              carry_q, carry_d;
    logic [WIDTH-1:0]  res_q, res_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              msb_cin_q, msb_cin_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic              cout_q, cout_d;

    logic fa_a, fa_b, fa_c1, fa_s, fa_c2;

    // Subtraction inverts B bit by bit; the +1 comes from the preloaded carry.
    assign fa_a  = a_sh_q[0];
    assign fa_b  = b_sh_q[0] ^ sub_q;
    assign fa_c1 = carry_q;

    full_add u_full_add (
        .a  (fa_a),
        .b  (fa_b),
        .c1 (fa_c1),
        .s  (fa_s),
        .c2 (fa_c2)
    );

    always_comb begin
        state_d   = state_q;
        a_sh_d    = a_sh_q;
        b_sh_d    = b_sh_q;
        sub_d     = sub_q;
        carry_d   = carry_q;
        res_d     = res_q;
        cnt_d     = cnt_q;
        msb_cin_d = msb_cin_q;
        sum_d     = sum_q;
        cout_d    = cout_q;

        case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                if (start) begin
                    a_sh_d  = a_in;
                    b_sh_d  = b_in;
                    sub_d   = sub;
                    carry_d = sub ? 1'b1 : cin;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                res_d   = {fa_s, res_q[WIDTH-1:1]};
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                carry_d = fa_c2;
                cnt_d   = cnt_q + CntW'(1);
                if (cnt_q == LastBit) begin
                    // Commit the finished result in one step.
                    msb_cin_d = fa_c1;
                    cout_d    = fa_c2;
                    sum_d     = {fa_s, res_q[WIDTH-1:1]};
                    cnt_d     = '0;
                    state_d   = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            a_sh_q    <= '0;
            b_sh_q    <= '0;
            sub_q     <= 1'b0;
            carry_q   <= 1'b0;
            res_q     <= '0;
            cnt_q     <= '0;
            msb_cin_q <= 1'b0;
            sum_q     <= '0;
            cout_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_sh_q    <= a_sh_d;
            b_sh_q    <= b_sh_d;
            sub_q     <= sub_d;
            carry_q   <= carry_d;
            res_q     <= res_d;
            cnt_q     <= cnt_d;
            msb_cin_q <= msb_cin_d;
            sum_q     <= sum_d;
            cout_q    <= cout_d;
        end
    end

    // All outputs are decodes of flops only; no input-to-output path.
    assign busy = (state_q == StRun);
    assign done = (state_q == StDone);
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = msb_cin_q ^ cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl. Expected results are pushed to a
// scoreboard queue when an operation is started and popped by a monitor when
// done pulses.
module tb_serial_add_ctrl;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         sub;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // {ovf, cout, sum}
    logic [W+1:0] sb_q[$];

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .sub   (sub),
        .a_in  (a_in),
        .b_in  (b_in),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required finish");
        $fatal(1);
    end

    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic c, input logic s);
        logic [W-1:0] bb;
        logic [W:0]   full;
        logic         o;
        bb   = s ? ~b : b;
        full = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, (s ? 1'b1 : c)};
        // Overflow: operands of equal sign giving a result of the other sign.
        o    = (a[W-1] == bb[W-1]) && (full[W-1] != a[W-1]);
        return {o, full[W], full[W-1:0]};
    endfunction

    // Scoreboard monitor.
    always @(negedge clk) begin
        logic [W+1:0] exp;
        if (done === 1'b1 && rst === 1'b0) begin
            if (sb_q.size() == 0) begin
                total_cnt++;
                $display("FAIL unexpected_done: got done=1 sum=%h, required no done", sum);
            end else begin
                exp = sb_q.pop_front();
                total_cnt++;
                if (sum !== exp[W-1:0])
                    $display("FAIL sum: got %h, required %h", sum, exp[W-1:0]);
                else pass_cnt++;
                total_cnt++;
                if (cout !== exp[W])
                    $display("FAIL cout (sum %h): got %b, required %b", exp[W-1:0], cout, exp[W]);
                else pass_cnt++;
                total_cnt++;
                if (ovf !== exp[W+1])
                    $display("FAIL ovf (sum %h): got %b, required %b", exp[W-1:0], ovf, exp[W+1]);
                else pass_cnt++;
            end
        end
    end

    // Called at a negedge; returns at the negedge of the first cycle after E0.
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                            input logic s, input logic expect_done);
        start = 1'b1;
        a_in  = a;
        b_in  = b;
        cin   = c;
        sub   = s;
        if (expect_done) sb_q.push_back(model(a, b, c, s));
        @(negedge clk);
        start = 1'b0;
        // Operands are sampled only at the start edge.
        a_in  = W'($urandom);
        b_in  = W'($urandom);
        cin   = 1'($urandom);
        sub   = 1'($urandom);
    endtask

    // Waits for done; k is the number of cycles since the start edge already seen.
    task automatic wait_done(input string name, input int k0, input logic chk_hold,
                             input logic [W-1:0] hold_val);
        int k = k0;
        int busy_n = 0;
        int hold_bad = 0;
        while (done !== 1'b1 && k < 40) begin
            if (busy === 1'b1) busy_n++;
            if (chk_hold && sum !== hold_val) hold_bad++;
            @(negedge clk);
            k++;
        end
        total_cnt++;
        if (done !== 1'b1)
            $display("FAIL %s_timeout: got no done after %0d cycles, required done", name, k);
        else pass_cnt++;
        total_cnt++;
        if (k !== W + 1)
            $display("FAIL %s_latency: got %0d, required %0d", name, k, W + 1);
        else pass_cnt++;
        if (k0 == 1) begin
            total_cnt++;
            if (busy_n !== W)
                $display("FAIL %s_busy_cycles: got %0d, required %0d", name, busy_n, W);
            else pass_cnt++;
        end
        if (chk_hold) begin
            total_cnt++;
            if (hold_bad !== 0)
                $display("FAIL %s_hold: got %0d cycles sum!=%h, required 0", name, hold_bad,
                         hold_val);
            else pass_cnt++;
        end
    endtask

    task automatic op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic c, input logic s);
        logic [W-1:0] res;
        start_op(a, b, c, s, 1'b1);
        wait_done(name, 1, 1'b0, '0);
        res = sum;
        @(negedge clk);
        total_cnt++;
        if (done !== 1'b0 || sum !== res)
            $display("FAIL %s_after_done: got done=%b sum=%h, required done=0 sum=%h", name,
                     done, sum, res);
        else pass_cnt++;
    endtask

    task automatic test_reset;
        rst   = 1'b1;
        start = 1'b0;
        sub   = 1'b0;
        a_in  = '0;
        b_in  = '0;
        cin   = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        total_cnt++;
        if ({busy, done, sum, cout, ovf} !== '0)
            $display("FAIL reset: got busy=%b done=%b sum=%h cout=%b ovf=%b, required all 0",
                     busy, done, sum, cout, ovf);
        else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_add;
        op("add_0f_01", 8'h0F, 8'h01, 1'b0, 1'b0);
        op("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0);
        op("add_7f_01", 8'h7F, 8'h01, 1'b0, 1'b0);
        op("add_00_cin", 8'h00, 8'h00, 1'b1, 1'b0);
        op("add_80_80", 8'h80, 8'h80, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++)
            op("add_rand", W'($urandom), W'($urandom), 1'($urandom), 1'b0);
    endtask

    task automatic test_sub;
        op("sub_05_07", 8'h05, 8'h07, 1'b0, 1'b1);
        op("sub_80_01", 8'h80, 8'h01, 1'b1, 1'b1);
        op("sub_00_00", 8'h00, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++)
            op("sub_rand", W'($urandom), W'($urandom), 1'($urandom), 1'b1);
    endtask

    task automatic test_start_in_run;
        int extra_done = 0;
        int extra_busy = 0;
        start_op(8'h10, 8'h20, 1'b0, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        start = 1'b1;
        a_in  = 8'hAA;
        b_in  = 8'h55;
        sub   = 1'b0;
        cin   = 1'b0;
        @(negedge clk);
        start = 1'b0;
        wait_done("start_in_run", 4, 1'b0, '0);
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done === 1'b1) extra_done++;
            if (busy === 1'b1) extra_busy++;
        end
        total_cnt++;
        if (extra_done !== 0 || extra_busy !== 0)
            $display("FAIL start_in_run_ignored: got %0d dones %0d busy, required 0 0",
                     extra_done, extra_busy);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back;
        start_op(8'h10, 8'h20, 1'b0, 1'b0, 1'b1);
        wait_done("b2b_first", 1, 1'b0, '0);
        // Still in the done cycle: a new start here is accepted.
        start_op(8'h01, 8'h02, 1'b0, 1'b0, 1'b1);
        wait_done("b2b_second", 1, 1'b1, 8'h30);
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int stray = 0;
        start_op(8'h3C, 8'h5A, 1'b0, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        start = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        total_cnt++;
        if ({busy, done, sum, cout, ovf} !== '0)
            $display("FAIL reset_mid: got busy=%b done=%b sum=%h cout=%b ovf=%b, required all 0",
                     busy, done, sum, cout, ovf);
        else pass_cnt++;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) stray++;
        end
        total_cnt++;
        if (stray !== 0)
            $display("FAIL reset_mid_quiet: got %0d active cycles, required 0", stray);
        else pass_cnt++;
        op("after_reset_11_22", 8'h11, 8'h22, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_start_in_run();
        test_back_to_back();
        test_reset_mid();
        repeat (3) @(negedge clk);
        total_cnt++;
        if (sb_q.size() != 0)
            $display("FAIL scoreboard_drain: got %0d pending, required 0", sb_q.size());
        else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Bit-serial add/subtract controller that time-shares a single `full_add` cell across a WIDTH-bit operand pair. It latches operands on a start request and sequences one bit per clock through the `full_add` instance, LSB first. It holds the running carry in a register and assembles the result in a shift register. It sits between a requesting datapath and the one-bit adder, trading latency for area.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2..32.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only when the block is idle or in its done cycle.
- sub  in  1  0 = A+B+cin, 1 = A−B (A + ~B + 1; cin ignored).
- a_in  in  WIDTH  operand A, latched with start.
- b_in  in  WIDTH  operand B, latched with start.
- cin  in  1  carry-in for add, latched with start.
- busy  out  1  high while bits are being processed.
- done  out  1  one-cycle pulse: result valid.
- sum  out  WIDTH  result, held stable from done until the next accepted start.
- cout  out  1  final carry out of MSB; for sub, 1 = no borrow.
- ovf  out  1  signed overflow = carry into MSB XOR carry out of MSB.

## Operation
- Internal: `full_add` instance (a, b, c1 → s, c2). It has the following registers:
  - shift registers `a_sh`, `b_sh`
  - carry flop
  - result shift register
  - bit counter of ceil(log2(WIDTH)) bits
  - MSB carry-in capture flop
- The full_add inputs are a = a_sh[0], b = b_sh[0] ^ sub_q, c1 = carry.
- FSM states:
  - IDLE: busy=0, done=0.
    - On start=1, latch a_in→a_sh, b_in→b_sh, and sub→sub_q.
    - Load carry = sub ? 1 : cin.
    - Clear counter and go to RUN.
  - RUN: busy=1. Each cycle:
    - Shift s into the result MSB and shift the result right.
    - Shift a_sh and b_sh right.
    - Load carry ← c2.
    - Increment the counter.
    - When the counter = WIDTH−1, capture the current c1 as MSB carry-in, write c2 to cout, and go to DONE.
  - DONE: busy=0, done=1 for exactly one cycle. Next state is IDLE.
    - start=1 here is accepted exactly as in IDLE: latch the new operands and go to RUN.
    - The next accepted start (from DONE or IDLE) leaves the previous sum/cout/ovf on the outputs until that new operation's own done.
- start while in RUN is ignored: no relatch, no effect on the in-flight operation.
- sum, cout and ovf update only at the transition into DONE. They are never partially visible.
- Arithmetic is modulo 2^WIDTH. ovf is computed for two's-complement interpretation in both modes.
- Reset values: busy=0, done=0, sum=0, cout=0, ovf=0, state=IDLE, all internal registers 0.
- Reset mid-operation aborts immediately: no done pulse, outputs return to reset values on the next edge.
- rst has priority over start on the same edge.

## Timing
- Let start be sampled high at edge E0.
- busy is high in cycles E0+1 … E0+WIDTH (WIDTH cycles).
- done is high in cycle E0+WIDTH+1; sum, cout and ovf are valid from that cycle onward.
- Latency from start to done is WIDTH+1 clocks. Throughput is one operation per WIDTH+1 clocks with back-to-back start held in DONE.
- Operands are sampled only at E0, so a_in, b_in, sub and cin may change freely afterwards.
- No combinational path from inputs to outputs; all outputs are registered.

## Test plan
- WIDTH=8, add 0x0F + 0x01, cin=0 → done at start+9 clocks; sum=0x10, cout=0, ovf=0; busy high exactly 8 cycles.
- Add 0xFF + 0x01, cin=0 → sum=0x00, cout=1, ovf=0. Add 0x7F + 0x01 → sum=0x80, cout=0, ovf=1. Add 0x00 + 0x00, cin=1 → sum=0x01.
- Sub 0x05 − 0x07 → sum=0xFE, cout=0 (borrow), ovf=0. Sub 0x80 − 0x01 → sum=0x7F, cout=1, ovf=1.
- Start 0x10+0x20. Pulse start with 0xAA+0x55 three cycles later (during RUN) → first result sum=0x30 only; no second done.
- Start held high through DONE with new operands 0x01+0x02 → second run begins immediately; sum=0x30 is held until the second done gives sum=0x03.
- rst asserted at RUN bit 4 → next cycle busy=0, sum=0, no done pulse. A subsequent start of 0x11+0x22 completes normally with sum=0x33.
